// File: rtl/serial_sub_nbit.sv
// Bit-serial N-bit subtractor (diff = a - b - bin), one bit per clock, LSB first.
// Optional two's-complement overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_nbit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             br_next;

    // Handshake: start is a request sampled only in IDLE or DONE; done is a
    // one-cycle pulse marking diff/bout valid; busy covers the shifting window.
    always_comb begin
        d_bit   = a_r[0] ^ b_r[0] ^ br;
        br_next = (~a_r[0] & b_r[0]) | (~a_r[0] & br) | (b_r[0] & br);
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    // Outputs are registered from the current state, so busy/done trail the
    // state by one edge and can never overlap on a back-to-back start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            busy <= (state == SHIFT);
            done <= (state == DONE);
            case (state)
                SHIFT: begin
                    res_r <= {d_bit, res_r[WIDTH-1:1]};
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    br    <= br_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= DONE;
                end
                default: begin
                    if (state == DONE) begin
                        diff <= res_r;
                        bout <= br;
`ifdef SERIAL_SUB_OVF_EN
                        ovf  <= (a_msb ^ b_msb) & (a_msb ^ res_r[WIDTH-1]);
`endif
                    end
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        br    <= bin;
                        cnt   <= '0;
                        state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Self-checking bench for serial_sub_nbit (WIDTH=4): vector table, corner
// sequences and random operations against an arithmetic reference model.
module tb_serial_sub_nbit;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;
    logic [W+1:0] exp_q[$];

    serial_sub_nbit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .bout  (bout),
        .ovf   (ovf)
`else
        .bout  (bout)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && busy && done) begin
            total++;
            bad++;
            $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both 1", busy, done);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference model: plain integer arithmetic, packed as {ovf, bout, diff}
    function automatic logic [W+1:0] model(input int av, input int bv, input int bi);
        int u;
        int s;
        logic [W-1:0] dv;
        logic bo;
        logic ov;
        u  = av - bv - bi;
        dv = W'(u & ((1 << W) - 1));
        bo = (u < 0);
        s  = ((av >= (1 << (W - 1))) ? av - (1 << W) : av)
           - ((bv >= (1 << (W - 1))) ? bv - (1 << W) : bv) - bi;
        ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
        return {ov, bo, dv};
    endfunction

    // Compare DUT outputs against the head of the expected queue.
    task automatic check_result(input string name);
        logic [W+1:0] e;
        if (exp_q.size() == 0) begin
            chk({name, "_queue"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk({name, "_diff"}, int'(diff), int'(e[W-1:0]));
        chk({name, "_bout"}, int'(bout), int'(e[W]));
`ifdef SERIAL_SUB_OVF_EN
        chk({name, "_ovf"}, int'(ovf), int'(e[W+1]));
`endif
    endtask

    // Drive one operation and wait (bounded) for done; check latency and busy.
    task automatic do_op(input string name, input int av, input int bv, input int bi);
        int k;
        int busy_cnt;
        @(negedge clk);
        a = W'(av); b = W'(bv); bin = bi[0]; start = 1'b1;
        exp_q.push_back(model(av, bv, bi));
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cnt++;
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
        end
        chk({name, "_latency"}, k, W + 1);
        chk({name, "_busycnt"}, busy_cnt, W);
        check_result(name);
    endtask

    typedef struct {
        int av;
        int bv;
        int bi;
        int ed;
        int eb;
        int eo;
    } vec_t;

    vec_t vecs[7];
    int   k;
    int   seen;

    initial begin
        vecs[0] = '{5, 3, 0, 2, 0, 0};
        vecs[1] = '{3, 5, 0, 14, 1, 0};
        vecs[2] = '{0, 0, 1, 15, 1, 0};
        vecs[3] = '{15, 15, 0, 0, 0, 0};
        vecs[4] = '{0, 15, 1, 0, 1, 0};
        vecs[5] = '{8, 1, 0, 7, 0, 1};
        vecs[6] = '{6, 2, 0, 4, 0, 0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_bout", int'(bout), 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", int'(ovf), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // table: hand constants, also cross-checked against the model
        for (int i = 0; i < 7; i++) begin
            chk("tbl_model", int'(model(vecs[i].av, vecs[i].bv, vecs[i].bi)),
                (vecs[i].eo << (W + 1)) | (vecs[i].eb << W) | vecs[i].ed);
            do_op($sformatf("vec%0d", i), vecs[i].av, vecs[i].bv, vecs[i].bi);
            chk($sformatf("vec%0d_hold", i), int'(diff), vecs[i].ed);
        end

        // start during SHIFT is ignored, and diff holds its old value meanwhile
        @(negedge clk);
        a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
        exp_q.push_back(model(9, 4, 0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd1; b = 4'd1; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_diff_held", int'(diff), 4);
        seen = 0;
        for (k = 3; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin seen = k; break; end
        end
        chk("ign_latency", seen, W + 1);
        check_result("ign");
        repeat (8) begin
            @(negedge clk);
            chk("ign_no_extra_done", int'(done), 0);
        end

        // start held high through DONE: back-to-back, no IDLE cycle
        a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
        exp_q.push_back(model(9, 4, 0));
        exp_q.push_back(model(12, 3, 0));
        @(negedge clk);
        a = 4'd12; b = 4'd3;
        seen = 0;
        for (k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                seen++;
                chk($sformatf("b2b_done%0d_edge", seen), k, seen * (W + 1));
                check_result("b2b");
                if (seen == 2) break;
            end
        end
        start = 1'b0;
        chk("b2b_count", seen, 2);

        // asynchronous reset mid-SHIFT aborts the operation
        @(negedge clk);
        @(negedge clk);
        a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_diff", int'(diff), 0);
        chk("abort_bout", int'(bout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        do_op("after_abort", 6, 1, 0);

        // random operations against the model
        for (int i = 0; i < 40; i++) begin
            do_op("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 1)));
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
